csr_file: RTL and testbench

- Machine-mode CSR storage for the 5-stage RV64 core; the receiving end of the writeback stage's CSR write port (CSR_wbEn/CSR_addr/CSR_value) and its commit-valid pulse.
- Gives decode/execute a combinational read port plus trap/mret state updates.
- Keeps mcycle/minstret counters.
- Exposes mtvec/mepc/mstatus to fetch and the commit/difftest logic.

---
 rtl/csr_file.sv | 191 +++++++++++++++++++
 tb/tb_csr_file.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV64 core: read port, writeback write port, trap/mret updates, mcycle/minstret.
// Optional `CSR_BYPASS_EN forwards a same-cycle writeback value to the read port.
module csr_file #(
    parameter logic [63:0] MISA_VALUE = 64'h8000000000000100,
    parameter logic [63:0] HART_ID    = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CSR_wbEn,
    input  logic [11:0] CSR_addr,
    input  logic [63:0] CSR_value,
    input  logic        commit_valid,
    input  logic [11:0] rd_addr,
    output logic [63:0] rd_data,
    output logic        rd_illegal,
    input  logic        trap_en,
    input  logic [63:0] trap_cause,
    input  logic [63:0] trap_pc,
    input  logic [63:0] trap_tval,
    input  logic        mret_en,
    output logic [63:0] mtvec_out,
    output logic [63:0] mepc_out,
    output logic [63:0] mstatus_out,
    output logic        wr_ignored
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_SATP     = 12'h180;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam logic [63:0] MSTATUS_MASK  = 64'h0000_0000_0000_1888;
    localparam logic [63:0] MSTATUS_RESET = 64'h0000_0000_0000_1800;

    logic [63:0] mstatus_q, mstatus_d;
    logic [63:0] mie_q, mie_d;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mscratch_q, mscratch_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;
    logic [63:0] mtval_q, mtval_d;
    logic [63:0] mip_q, mip_d;
    logic [63:0] satp_q, satp_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic        wr_ignored_q, wr_ignored_d;

    logic [63:0] wrData;
    logic [63:0] regData;

    function automatic logic isWritable(input logic [11:0] addr);
        case (addr)
            ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
            ADDR_MCAUSE, ADDR_MTVAL, ADDR_MIP, ADDR_SATP,
            ADDR_MCYCLE, ADDR_MINSTRET: isWritable = 1'b1;
            default:                    isWritable = 1'b0;
        endcase
    endfunction

    // Masks are applied on the way in, so stored values already read back in their legal form.
    function automatic logic [63:0] writeMask(input logic [11:0] addr, input logic [63:0] value);
        case (addr)
            ADDR_MSTATUS: writeMask = value & MSTATUS_MASK;
            ADDR_MTVEC:   writeMask = value & ~64'h2;
            ADDR_MEPC:    writeMask = value & ~64'h3;
            default:      writeMask = value;
        endcase
    endfunction

    assign wrData = writeMask(CSR_addr, CSR_value);

    always_comb begin
        mstatus_d    = mstatus_q;
        mie_d        = mie_q;
        mtvec_d      = mtvec_q;
        mscratch_d   = mscratch_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mtval_d      = mtval_q;
        mip_d        = mip_q;
        satp_d       = satp_q;
        mcycle_d     = mcycle_q + 64'd1;
        minstret_d   = minstret_q + {63'd0, commit_valid};
        wr_ignored_d = wr_ignored_q | (CSR_wbEn & ~isWritable(CSR_addr));

        if (CSR_wbEn) begin
            case (CSR_addr)
                ADDR_MSTATUS:  mstatus_d  = wrData;
                ADDR_MIE:      mie_d      = wrData;
                ADDR_MTVEC:    mtvec_d    = wrData;
                ADDR_MSCRATCH: mscratch_d = wrData;
                ADDR_MEPC:     mepc_d     = wrData;
                ADDR_MCAUSE:   mcause_d   = wrData;
                ADDR_MTVAL:    mtval_d    = wrData;
                ADDR_MIP:      mip_d      = wrData;
                ADDR_SATP:     satp_d     = wrData;
                ADDR_MCYCLE:   mcycle_d   = wrData;
                ADDR_MINSTRET: minstret_d = wrData;
                default: ;
            endcase
        end

        // Trap beats mret beats the writeback write; both start from the old mstatus.
        if (trap_en) begin
            mepc_d             = trap_pc & ~64'h3;
            mcause_d           = trap_cause;
            mtval_d            = trap_tval;
            mstatus_d          = mstatus_q;
            mstatus_d[7]       = mstatus_q[3];
            mstatus_d[3]       = 1'b0;
            mstatus_d[12:11]   = 2'b11;
        end else if (mret_en) begin
            mstatus_d          = mstatus_q;
            mstatus_d[3]       = mstatus_q[7];
            mstatus_d[7]       = 1'b1;
            mstatus_d[12:11]   = 2'b11;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q    <= MSTATUS_RESET;
            mie_q        <= '0;
            mtvec_q      <= '0;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            mip_q        <= '0;
            satp_q       <= '0;
            mcycle_q     <= '0;
            minstret_q   <= '0;
            wr_ignored_q <= 1'b0;
        end else begin
            mstatus_q    <= mstatus_d;
            mie_q        <= mie_d;
            mtvec_q      <= mtvec_d;
            mscratch_q   <= mscratch_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            mtval_q      <= mtval_d;
            mip_q        <= mip_d;
            satp_q       <= satp_d;
            mcycle_q     <= mcycle_d;
            minstret_q   <= minstret_d;
            wr_ignored_q <= wr_ignored_d;
        end
    end

    always_comb begin
        regData    = '0;
        rd_illegal = 1'b0;
        case (rd_addr)
            ADDR_MSTATUS:  regData = mstatus_q;
            ADDR_MISA:     regData = MISA_VALUE;
            ADDR_MIE:      regData = mie_q;
            ADDR_MTVEC:    regData = mtvec_q;
            ADDR_MSCRATCH: regData = mscratch_q;
            ADDR_MEPC:     regData = mepc_q;
            ADDR_MCAUSE:   regData = mcause_q;
            ADDR_MTVAL:    regData = mtval_q;
            ADDR_MIP:      regData = mip_q;
            ADDR_SATP:     regData = satp_q;
            ADDR_MCYCLE:   regData = mcycle_q;
            ADDR_MINSTRET: regData = minstret_q;
            ADDR_MHARTID:  regData = HART_ID;
            default:       rd_illegal = 1'b1;
        endcase
    end

`ifdef CSR_BYPASS_EN
    assign rd_data = (CSR_wbEn && (CSR_addr == rd_addr) && isWritable(rd_addr)) ? wrData : regData;
`else
    assign rd_data = regData;
`endif

    assign mtvec_out   = mtvec_q;
    assign mepc_out    = mepc_q;
    assign mstatus_out = mstatus_q;
    assign wr_ignored  = wr_ignored_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; honours `CSR_BYPASS_EN when building expectations.
module tb_csr_file;

    localparam logic [63:0] MISA_EXP = 64'h8000000000000100;

    logic        clk;
    logic        rst;
    logic        CSR_wbEn;
    logic [11:0] CSR_addr;
    logic [63:0] CSR_value;
    logic        commit_valid;
    logic [11:0] rd_addr;
    logic [63:0] rd_data;
    logic        rd_illegal;
    logic        trap_en;
    logic [63:0] trap_cause;
    logic [63:0] trap_pc;
    logic [63:0] trap_tval;
    logic        mret_en;
    logic [63:0] mtvec_out;
    logic [63:0] mepc_out;
    logic [63:0] mstatus_out;
    logic        wr_ignored;

    int total = 0;
    int bad   = 0;

    csr_file dut (
        .clk(clk), .rst(rst),
        .CSR_wbEn(CSR_wbEn), .CSR_addr(CSR_addr), .CSR_value(CSR_value),
        .commit_valid(commit_valid),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_illegal(rd_illegal),
        .trap_en(trap_en), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret_en(mret_en),
        .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mstatus_out(mstatus_out),
        .wr_ignored(wr_ignored)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; one rising edge then back to the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic writeCsr(input logic [11:0] addr, input logic [63:0] value);
        CSR_wbEn  = 1'b1;
        CSR_addr  = addr;
        CSR_value = value;
        tick();
        CSR_wbEn  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        writeCsr(12'h340, 64'h123);
        writeCsr(12'hF14, 64'h5);
        for (int i = 0; i < 48; i++) begin
            commit_valid = (i < 20);
            tick();
        end
        commit_valid = 1'b0;
        rd_addr = 12'hB00; #1;
        total++; if (rd_data !== 64'd50) begin bad++; $display("[TB] FAIL mcycle_run got=%0h exp=%0h", rd_data, 64'd50); end
        rd_addr = 12'hB02; #1;
        total++; if (rd_data !== 64'd20) begin bad++; $display("[TB] FAIL minstret_run got=%0h exp=%0h", rd_data, 64'd20); end
        total++; if (wr_ignored !== 1'b1) begin bad++; $display("[TB] FAIL ign_before_rst got=%0b exp=1", wr_ignored); end
        rst = 1'b1; #1;
        rd_addr = 12'hB00; #1;
        total++; if (rd_data !== 64'd0) begin bad++; $display("[TB] FAIL rst_mcycle got=%0h exp=0", rd_data); end
        rd_addr = 12'hB02; #1;
        total++; if (rd_data !== 64'd0) begin bad++; $display("[TB] FAIL rst_minstret got=%0h exp=0", rd_data); end
        rd_addr = 12'h340; #1;
        total++; if (rd_data !== 64'd0) begin bad++; $display("[TB] FAIL rst_mscratch got=%0h exp=0", rd_data); end
        rd_addr = 12'h300; #1;
        total++; if (rd_data !== 64'h1800) begin bad++; $display("[TB] FAIL rst_mstatus got=%0h exp=1800", rd_data); end
        rd_addr = 12'h301; #1;
        total++; if (rd_data !== MISA_EXP) begin bad++; $display("[TB] FAIL rst_misa got=%0h exp=%0h", rd_data, MISA_EXP); end
        total++; if (wr_ignored !== 1'b0) begin bad++; $display("[TB] FAIL rst_ign got=%0b exp=0", wr_ignored); end
        total++; if (mstatus_out !== 64'h1800) begin bad++; $display("[TB] FAIL rst_mstatus_out got=%0h exp=1800", mstatus_out); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_scratch_and_ro();
        rd_addr = 12'h340;
        writeCsr(12'h340, 64'hDEADBEEF_CAFEF00D);
        #1;
        total++; if (rd_data !== 64'hDEADBEEF_CAFEF00D) begin bad++; $display("[TB] FAIL mscratch got=%0h exp=deadbeefcafef00d", rd_data); end
        total++; if (wr_ignored !== 1'b0) begin bad++; $display("[TB] FAIL ign_legal got=%0b exp=0", wr_ignored); end
        writeCsr(12'h301, 64'h0);
        rd_addr = 12'h301; #1;
        total++; if (rd_data !== MISA_EXP) begin bad++; $display("[TB] FAIL misa_ro got=%0h exp=%0h", rd_data, MISA_EXP); end
        total++; if (wr_ignored !== 1'b1) begin bad++; $display("[TB] FAIL ign_set got=%0b exp=1", wr_ignored); end
        tick();
        tick();
        total++; if (wr_ignored !== 1'b1) begin bad++; $display("[TB] FAIL ign_sticky got=%0b exp=1", wr_ignored); end
        rd_addr = 12'hF14; #1;
        total++; if (rd_data !== 64'd0 || rd_illegal !== 1'b0) begin bad++; $display("[TB] FAIL mhartid got=%0h ill=%0b exp=0 ill=0", rd_data, rd_illegal); end
        rst = 1'b1; #1;
        total++; if (wr_ignored !== 1'b0) begin bad++; $display("[TB] FAIL ign_clear got=%0b exp=0", wr_ignored); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_counters();
        rd_addr      = 12'hB00;
        commit_valid = 1'b1;
        writeCsr(12'hB00, 64'hFFFFFFFF_FFFFFFFE);
        commit_valid = 1'b0;
        #1;
        total++; if (rd_data !== 64'hFFFFFFFF_FFFFFFFE) begin bad++; $display("[TB] FAIL mcycle_wr got=%0h exp=fffffffffffffffe", rd_data); end
        tick();
        total++; if (rd_data !== 64'hFFFFFFFF_FFFFFFFF) begin bad++; $display("[TB] FAIL mcycle_max got=%0h exp=ffffffffffffffff", rd_data); end
        tick();
        total++; if (rd_data !== 64'd0) begin bad++; $display("[TB] FAIL mcycle_wrap got=%0h exp=0", rd_data); end
        rd_addr      = 12'hB02;
        commit_valid = 1'b1;
        writeCsr(12'hB02, 64'd10);
        commit_valid = 1'b0;
        #1;
        total++; if (rd_data !== 64'd10) begin bad++; $display("[TB] FAIL minstret_wr got=%0h exp=a", rd_data); end
        tick();
        total++; if (rd_data !== 64'd10) begin bad++; $display("[TB] FAIL minstret_idle got=%0h exp=a", rd_data); end
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        #1;
        total++; if (rd_data !== 64'd11) begin bad++; $display("[TB] FAIL minstret_inc got=%0h exp=b", rd_data); end
    endtask

    task automatic test_trap_mret();
        writeCsr(12'h300, 64'hFFFFFFFF_FFFFFFFF);
        total++; if (mstatus_out !== 64'h1888) begin bad++; $display("[TB] FAIL mstatus_mask got=%0h exp=1888", mstatus_out); end
        writeCsr(12'h300, 64'h1808);
        total++; if (mstatus_out !== 64'h1808) begin bad++; $display("[TB] FAIL mstatus_mie got=%0h exp=1808", mstatus_out); end
        trap_en = 1'b1; trap_pc = 64'h80000006; trap_cause = 64'd2; trap_tval = 64'h55;
        writeCsr(12'h341, 64'd5);
        trap_en = 1'b0;
        total++; if (mepc_out !== 64'h80000004) begin bad++; $display("[TB] FAIL trap_mepc got=%0h exp=80000004", mepc_out); end
        rd_addr = 12'h342; #1;
        total++; if (rd_data !== 64'd2) begin bad++; $display("[TB] FAIL trap_mcause got=%0h exp=2", rd_data); end
        rd_addr = 12'h343; #1;
        total++; if (rd_data !== 64'h55) begin bad++; $display("[TB] FAIL trap_mtval got=%0h exp=55", rd_data); end
        total++; if (mstatus_out !== 64'h1880) begin bad++; $display("[TB] FAIL trap_mstatus got=%0h exp=1880", mstatus_out); end
        mret_en = 1'b1;
        tick();
        mret_en = 1'b0;
        total++; if (mstatus_out !== 64'h1888) begin bad++; $display("[TB] FAIL mret_mstatus got=%0h exp=1888", mstatus_out); end
        trap_en = 1'b1; trap_pc = 64'h200; trap_cause = 64'd7; trap_tval = 64'd0;
        writeCsr(12'h340, 64'h77);
        trap_en = 1'b0;
        rd_addr = 12'h340; #1;
        total++; if (rd_data !== 64'h77) begin bad++; $display("[TB] FAIL trap_side_write got=%0h exp=77", rd_data); end
        total++; if (mepc_out !== 64'h200 || mstatus_out !== 64'h1880) begin bad++; $display("[TB] FAIL trap2 mepc=%0h mstatus=%0h exp 200 1880", mepc_out, mstatus_out); end
        trap_en = 1'b1; mret_en = 1'b1;
        tick();
        trap_en = 1'b0; mret_en = 1'b0;
        total++; if (mstatus_out !== 64'h1800) begin bad++; $display("[TB] FAIL trap_over_mret got=%0h exp=1800", mstatus_out); end
    endtask

    task automatic test_read_masks();
        rd_addr = 12'h7C0; #1;
        total++; if (rd_illegal !== 1'b1 || rd_data !== 64'd0) begin bad++; $display("[TB] FAIL unimpl ill=%0b data=%0h exp ill=1 data=0", rd_illegal, rd_data); end
        rd_addr = 12'h341;
        writeCsr(12'h341, 64'h1003);
        #1;
        total++; if (rd_data !== 64'h1000 || mepc_out !== 64'h1000) begin bad++; $display("[TB] FAIL mepc_mask rd=%0h out=%0h exp=1000", rd_data, mepc_out); end
        total++; if (rd_illegal !== 1'b0) begin bad++; $display("[TB] FAIL mepc_legal got=%0b exp=0", rd_illegal); end
    endtask

    task automatic test_bypass();
        logic [63:0] expSame;
        rd_addr = 12'h305;
        writeCsr(12'h305, 64'h100);
`ifdef CSR_BYPASS_EN
        expSame = 64'h80001000;
`else
        expSame = 64'h100;
`endif
        CSR_wbEn = 1'b1; CSR_addr = 12'h305; CSR_value = 64'h80001002;
        #1;
        total++; if (rd_data !== expSame) begin bad++; $display("[TB] FAIL mtvec_same_cycle got=%0h exp=%0h", rd_data, expSame); end
        total++; if (mtvec_out !== 64'h100) begin bad++; $display("[TB] FAIL mtvec_out_unbypassed got=%0h exp=100", mtvec_out); end
        tick();
        CSR_wbEn = 1'b0;
        #1;
        total++; if (rd_data !== 64'h80001000 || mtvec_out !== 64'h80001000) begin bad++; $display("[TB] FAIL mtvec_next rd=%0h out=%0h exp=80001000", rd_data, mtvec_out); end
    endtask

    initial begin
        rst = 1'b1; CSR_wbEn = 1'b0; CSR_addr = '0; CSR_value = '0; commit_valid = 1'b0;
        rd_addr = '0; trap_en = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0; mret_en = 1'b0;
        @(negedge clk);
        test_reset();
        test_scratch_and_ro();
        test_counters();
        test_trap_mret();
        test_read_masks();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
